conv_window_mac_ctrl: RTL and testbench

- Sequences one convolution window through a single shared multiply-accumulate datapath.
- Accepts a start command with a bias, then streams KSIZE*KSIZE signed Q5.11 pixel/weight pairs through a valid/ready handshake.
- Accumulates the Q10.22 products at full precision, saturates and truncates the sum back to Q5.11, and holds the result until the downstream stage (pooling/activation buffer) accepts it.

---
 rtl/conv_window_mac_ctrl_pkg.sv | 26 ++
 rtl/conv_window_mac_ctrl_if.sv | 34 +++
 rtl/conv_window_mac_ctrl_acc_saturate.sv | 46 ++++
 rtl/conv_window_mac_ctrl.sv | 94 +++++++++
 tb/tb_conv_window_mac_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_window_mac_ctrl_pkg.sv
// ============================================================================
// Module : conv_window_mac_ctrl_pkg
// Brief  : Shared fixed-point constants and FSM encoding for the window MAC.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package conv_window_mac_ctrl_pkg;

   localparam int FRAC_BITS = 11;
   localparam int PROD_FRAC = 22;
   localparam int DATA_W    = 16;

   localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
   localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_SAT  = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/conv_window_mac_ctrl_if.sv
// ============================================================================
// Module : conv_window_mac_ctrl_if
// Brief  : Command, pair-stream and result handshake bundle for the window MAC.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface conv_window_mac_ctrl_if;
   import conv_window_mac_ctrl_pkg::*;

   logic              start;
   logic [DATA_W-1:0] bias;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] pixel;
   logic [DATA_W-1:0] weight;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              busy;

   modport master (
      output start, bias, in_valid, pixel, weight, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  start, bias, in_valid, pixel, weight, out_ready,
      output in_ready, out_valid, out_data, busy
   );

endinterface

`default_nettype wire

// File: rtl/conv_window_mac_ctrl_acc_saturate.sv
// ============================================================================
// Module : acc_saturate
// Brief  : Q.22 accumulator (fraction LSBs below Q.11 already dropped) to
//          saturated Q5.11, truncating toward -inf, optional ReLU clamp.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module acc_saturate
   import conv_window_mac_ctrl_pkg::*;
#(
   parameter int ACC_W = 40,
   parameter int RELU  = 0
) (
   input  wire logic [ACC_W-FRAC_BITS-1:0] acc,
   output logic      [DATA_W-1:0]          data
);

   // Result fits Q5.11 exactly when every bit from the Q5.11 sign upward agrees.
   localparam int TOP_LSB = DATA_W - 1;

   logic [ACC_W-FRAC_BITS-1-TOP_LSB:0] w_upper;
   logic                               w_fits;
   logic [DATA_W-1:0]                  w_sat;

   assign w_upper = acc[ACC_W-FRAC_BITS-1:TOP_LSB];
   assign w_fits  = (&w_upper) | ~(|w_upper);

   always_comb begin
      w_sat = acc[DATA_W-1:0];
      if (!w_fits) begin
         w_sat = acc[ACC_W-FRAC_BITS-1] ? Q_MIN : Q_MAX;
      end
   end

   generate
      if (RELU != 0) begin : g_relu
         assign data = w_sat[DATA_W-1] ? '0 : w_sat;
      end else begin : g_no_relu
         assign data = w_sat;
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/conv_window_mac_ctrl.sv
// ============================================================================
// Module : conv_window_mac_ctrl
// Brief  : Streams one KSIZE*KSIZE window through a shared MAC, saturates to
//          Q5.11 and holds the result until downstream accepts it.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module conv_window_mac_ctrl
   import conv_window_mac_ctrl_pkg::*;
#(
   parameter int KSIZE = 5,
   parameter int ACC_W = 40,
   parameter int RELU  = 0
) (
   input wire logic                   clk,
   input wire logic                   rst,
   conv_window_mac_ctrl_if.slave      bus
);

   localparam int              NPAIRS = KSIZE * KSIZE;
   localparam int              CNT_W  = $clog2(NPAIRS + 1);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NPAIRS - 1);

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_count;
   logic [ACC_W-1:0]   r_acc;
   logic [DATA_W-1:0]  r_out_data;
   logic [DATA_W-1:0]  w_sat_data;
   logic signed [31:0] w_prod;
   logic               w_accept;
   logic               w_last;

   assign w_prod   = $signed(bus.pixel) * $signed(bus.weight);
   assign w_accept = bus.in_valid && (r_state == ST_MAC);
   assign w_last   = w_accept && (r_count == C_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (bus.start)     w_next = ST_MAC;
         ST_MAC:  if (w_last)        w_next = ST_SAT;
         ST_SAT:                     w_next = ST_HOLD;
         ST_HOLD: if (bus.out_ready) w_next = ST_IDLE;
         default:                    w_next = ST_IDLE;
      endcase
   end

   // Bias is aligned to the Q.22 product grid so products add without shifting.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count    <= '0;
         r_acc      <= '0;
         r_out_data <= '0;
      end else begin
         if (r_state == ST_IDLE && bus.start) begin
            r_acc   <= {{(ACC_W-DATA_W-FRAC_BITS){bus.bias[DATA_W-1]}},
                        bus.bias, {FRAC_BITS{1'b0}}};
            r_count <= '0;
         end else if (w_accept) begin
            r_acc   <= r_acc + {{(ACC_W-32){w_prod[31]}}, w_prod};
            r_count <= r_count + 1'b1;
         end
         if (r_state == ST_SAT) begin
            r_out_data <= w_sat_data;
         end
      end
   end

   acc_saturate #(
      .ACC_W (ACC_W),
      .RELU  (RELU)
   ) u_sat (
      .acc  (r_acc[ACC_W-1:FRAC_BITS]),
      .data (w_sat_data)
   );

   assign bus.in_ready  = (r_state == ST_MAC);
   assign bus.out_valid = (r_state == ST_HOLD);
   assign bus.out_data  = r_out_data;
   assign bus.busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_conv_window_mac_ctrl.sv
// ============================================================================
// Module : tb_conv_window_mac_ctrl
// Brief  : Scoreboard bench; RELU=0 and RELU=1 instances share one stimulus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_conv_window_mac_ctrl;

   localparam int KS = 3;
   localparam int NP = KS * KS;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] bias = '0;
   logic        in_valid = 1'b0;
   logic [15:0] pixel = '0;
   logic [15:0] weight = '0;
   logic        out_ready = 1'b0;
   logic        force_low = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   logic [15:0] pv [NP];
   logic [15:0] wv [NP];
   logic [15:0] qa[$];
   logic [15:0] qr[$];

   always #5 clk = ~clk;

   conv_window_mac_ctrl_if ifa ();
   conv_window_mac_ctrl_if ifr ();

   assign ifa.start = start;     assign ifr.start = start;
   assign ifa.bias = bias;       assign ifr.bias = bias;
   assign ifa.in_valid = in_valid; assign ifr.in_valid = in_valid;
   assign ifa.pixel = pixel;     assign ifr.pixel = pixel;
   assign ifa.weight = weight;   assign ifr.weight = weight;
   assign ifa.out_ready = out_ready; assign ifr.out_ready = out_ready;

   conv_window_mac_ctrl #(.KSIZE(KS), .ACC_W(40), .RELU(0)) dut (
      .clk (clk), .rst (rst), .bus (ifa.slave)
   );
   conv_window_mac_ctrl #(.KSIZE(KS), .ACC_W(40), .RELU(1)) dut_relu (
      .clk (clk), .rst (rst), .bus (ifr.slave)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   // Exact real-valued sum, floored to the Q.11 grid and clamped to 16 bits.
   function automatic logic [15:0] model(input logic [15:0] b, input bit relu);
      longint acc;
      longint q;
      acc = longint'($signed(b)) * 2048;
      for (int i = 0; i < NP; i++)
         acc += longint'($signed(pv[i])) * longint'($signed(wv[i]));
      q = acc >>> 11;
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      if (relu && q < 0) q = 0;
      return q[15:0];
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst && ifa.out_valid && out_ready) begin
            if (qa.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_out_a: got %h, expected no output", ifa.out_data);
            end else check("out_data_a", ifa.out_data, qa.pop_front());
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst && ifr.out_valid && out_ready) begin
            if (qr.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_out_relu: got %h, expected no output", ifr.out_data);
            end else check("out_data_relu", ifr.out_data, qr.pop_front());
         end
      end
   end

   task automatic wait_idle();
      int g = 0;
      while (ifa.busy && g < 300) begin
         @(negedge clk);
         g++;
      end
      if (g >= 300) check("wait_idle_timeout", 32'(ifa.busy), 32'd0);
   endtask

   task automatic feed_pair(input int i, input bit gaps);
      int g = 0;
      int n = gaps ? $urandom_range(0, 2) : 0;
      repeat (n) begin
         in_valid = 1'b0;
         pixel    = 16'($urandom);
         weight   = 16'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b1;
      pixel    = pv[i];
      weight   = wv[i];
      while (!ifa.in_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (g >= 50) check("in_ready_timeout", 32'(ifa.in_ready), 32'd1);
      @(negedge clk);
   endtask

   task automatic run_window(input logic [15:0] b, input bit gaps, input bit start_mid,
                             input bit lat_chk, input bit stall_chk);
      logic [15:0] d0;
      wait_idle();
      start = 1'b1;
      bias  = b;
      @(negedge clk);
      start = 1'b0;
      bias  = 16'($urandom);
      check("busy_after_start", 32'(ifa.busy), 32'd1);
      qa.push_back(model(b, 1'b0));
      qr.push_back(model(b, 1'b1));
      for (int i = 0; i < NP; i++) begin
         start = start_mid && (i == 4);
         feed_pair(i, gaps);
         start = 1'b0;
      end
      in_valid = 1'b0;
      if (lat_chk) begin
         check("sat_out_valid", 32'(ifa.out_valid), 32'd0);
         check("sat_in_ready", 32'(ifa.in_ready), 32'd0);
         @(negedge clk);
         check("hold_out_valid", 32'(ifa.out_valid), 32'd1);
         check("hold_busy", 32'(ifa.busy), 32'd1);
      end
      if (stall_chk) begin
         d0 = ifa.out_data;
         repeat (4) begin
            @(negedge clk);
            check("stall_data", 32'(ifa.out_data), 32'(d0));
            check("stall_valid", 32'(ifa.out_valid), 32'd1);
            check("stall_in_ready", 32'(ifa.in_ready), 32'd0);
         end
         force_low = 1'b0;
      end
   endtask

   task automatic fill(input logic [15:0] p, input logic [15:0] w);
      for (int i = 0; i < NP; i++) begin
         pv[i] = p;
         wv[i] = w;
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_in_ready"},  32'(ifa.in_ready),  32'd0);
      check({tag, "_out_valid"}, 32'(ifa.out_valid), 32'd0);
      check({tag, "_out_data"},  32'(ifa.out_data),  32'd0);
      check({tag, "_busy"},      32'(ifa.busy),      32'd0);
      check({tag, "_relu_busy"}, 32'(ifr.busy),      32'd0);
      check({tag, "_relu_data"}, 32'(ifr.out_data),  32'd0);
   endtask

   initial begin
      int g;
      logic [15:0] r;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      fill(16'h0800, 16'h0800);
      run_window(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
      fill(16'h0400, 16'h0800);
      run_window(16'h0400, 1'b0, 1'b0, 1'b0, 1'b0);
      fill(16'h7FFF, 16'h0800);
      run_window(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      fill(16'h8000, 16'h0800);
      run_window(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      fill(16'h0000, 16'h0000);
      pv[0] = 16'h8000; wv[0] = 16'h0800;
      run_window(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      fill(16'h0000, 16'h0000);
      run_window(16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         pv[i] = 16'hF800; wv[i] = 16'h0800;
      end
      run_window(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < NP; i++) begin
         pv[i] = 16'($urandom_range(0, 16'h0FFF));
         wv[i] = 16'h0800 - 16'($urandom_range(0, 16'h0FFF));
      end
      run_window(16'h0123, 1'b1, 1'b1, 1'b1, 1'b0);

      wait_idle();
      force_low = 1'b1;
      fill(16'h0800, 16'h0800);
      run_window(16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);

      wait_idle();
      start = 1'b1;
      bias  = 16'h1234;
      @(negedge clk);
      start    = 1'b0;
      fill(16'h2000, 16'h2000);
      in_valid = 1'b1;
      pixel    = pv[0];
      weight   = wv[0];
      g = 0;
      while (g < 4) begin
         if (ifa.in_ready) g++;
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      check_zero_outputs("midreset");
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      fill(16'h0800, 16'h0800);
      run_window(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);

      for (int k = 0; k < 20; k++) begin
         for (int i = 0; i < NP; i++) begin
            if (k % 2 == 0) begin
               pv[i] = 16'($urandom);
               wv[i] = 16'($urandom);
            end else begin
               r = 16'($urandom);
               pv[i] = {{5{r[10]}}, r[10:0]};
               r = 16'($urandom);
               wv[i] = {{5{r[10]}}, r[10:0]};
            end
         end
         run_window(16'($urandom), 1'b1, ($urandom_range(0, 1) == 1), 1'b0, 1'b0);
      end

      g = 0;
      while ((qa.size() != 0 || qr.size() != 0) && g < 300) begin
         @(negedge clk);
         g++;
      end
      check("drain_a", 32'(qa.size()), 32'd0);
      check("drain_relu", 32'(qr.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
